sigma_delta_adc: RTL and testbench
==================================

SIGMA_DELTA_ADC -- requirements
Module: sigma_delta_adc

Interface
REQ-001 SHALL provide parameter MSBO, default 13, MSB index of ADCout (output width MSBO+1).
REQ-002 SHALL provide parameter DEC_LOG2, default 7, log2 of decimation ratio R=2**DEC_LOG2; elaboration error unless 2*DEC_LOG2 >= MSBO+1.
REQ-003 SHALL provide parameter INV, default 1'b1, polarity of FBout relative to the sampled comparator bit.
REQ-004 SHALL provide port CLK  input  1  sampling/system clock.
REQ-005 SHALL provide port RESET  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port CMPin  input  1  external comparator output (asynchronous to CLK).
REQ-007 SHALL provide port FBout  output  1  1-bit feedback to external RC integrator.
REQ-008 SHALL provide port ADCout  output  MSBO+1  decimated sample, unipolar, excess 2**MSBO.
REQ-009 SHALL provide port ADCvalid  output  1  one-CLK strobe marking a new ADCout.

Function
REQ-010 SHALL pass CMPin through a 2-flop synchronizer; the second flop output is the modulator bit b.
REQ-011 SHALL register FBout <= b ^ INV each CLK (feedback loop latency 3 edges from CMPin).
REQ-012 SHALL filter b with a 2nd-order CIC (sinc2) decimator; accumulator width W=2*DEC_LOG2+1.
REQ-013 SHALL run integrator I1 <= I1 + b and I2 <= I2 + I1 every CLK, modulo 2**W (wrap is intentional, no saturation).
REQ-014 SHALL run decimation counter D 0..R-1, wrapping R-1 -> 0; tick = (D == R-1).
REQ-015 SHALL, on each tick edge, compute comb C1 = I2 - I2_prev and C2 = C1 - C1_prev (modulo 2**W) and update I2_prev, C1_prev.
REQ-016 SHALL treat C2 as an unsigned count in [0, R**2]; value R**2 saturates to R**2-1.
REQ-017 SHALL set ADCout = saturated C2 >> (2*DEC_LOG2 - (MSBO+1)) on the tick edge; ADCout holds between ticks.
REQ-018 SHALL assert ADCvalid for exactly the one cycle after a tick edge that updates ADCout; deassert at all other times.
REQ-019 SHALL suppress ADCvalid and ADCout updates for the first 2 ticks after reset (comb settling); the first valid sample follows the 3rd tick (edge 3*R after reset release).
REQ-020 SHALL produce ADCvalid period exactly R cycles in steady state; no back-pressure, samples not consumed are overwritten.

Reset
REQ-021 SHALL, on RESET, asynchronously clear synchronizer flops, I1, I2, I2_prev, C1_prev, D, settle counter, ADCout and ADCvalid to 0.
REQ-022 SHALL set FBout = INV during reset (equivalent to b=0).
REQ-023 SHALL restart settling (REQ-019) after any reset, including reset asserted mid-period; no stale sample emitted.

Structure
REQ-024 SHALL place W and the saturation constant computation in shared package sigma_delta_pkg, reused by the DAC side for width checks.
REQ-025 SHALL implement the integrators, combs, decimation counter and saturation in sub-module cic2_decimator; top level holds synchronizer, FBout and settling logic.
REQ-026 SHALL contain no combinational path from CMPin to any output.

Verification (defaults MSBO=13, DEC_LOG2=7, R=128, INV=1)
REQ-027 SHALL check CMPin held 0 -> FBout=1 constantly; first ADCvalid one cycle after edge 384 after reset release; ADCout=0.
REQ-028 SHALL check CMPin held 1 -> FBout=0 after 3 edges; every valid sample ADCout=16383 (saturated from 16384).
REQ-029 SHALL check CMPin toggling every CLK -> steady-state ADCout=8192 each sample; ADCvalid spacing exactly 128 cycles.
REQ-030 SHALL check CMPin with 1-density 1/4 (pattern 1000 repeating) -> steady-state ADCout=4096.
REQ-031 SHALL check RESET pulsed at D=60 mid-stream -> all outputs 0, FBout=1 immediately; no ADCvalid until edge 384 after release.
REQ-032 SHALL check integrator wrap: run 1-density 1/2 input >70000 cycles -> ADCout remains 8192 across I2 wrap-around.

Source files
------------

// File: rtl/sigma_delta_pkg.sv
// sigma_delta_pkg: CIC widths and saturation limits shared by the ADC and DAC sides.
`default_nettype none

package sigma_delta_pkg;

   // Second-order CIC needs 2*log2(R) bits of growth plus one so R**2 itself is representable.
   function automatic int cic_width(input int dec_log2);
      return 2 * dec_log2 + 1;
   endfunction

   function automatic int cic_sat_max(input int dec_log2);
      return (1 << (2 * dec_log2)) - 1;
   endfunction

   typedef enum logic [1:0] {
      SETTLE_0   = 2'd0,
      SETTLE_1   = 2'd1,
      SETTLE_RUN = 2'd2
   } settle_state_e;

endpackage

`default_nettype wire

// File: rtl/sigma_delta_adc_if.sv
// sigma_delta_adc_if: comparator/feedback pins and decimated sample bus of the ADC.
`default_nettype none

interface sigma_delta_adc_if #(
   parameter int MSBO = 13
);
   logic          CMPin;
   logic          FBout;
   logic [MSBO:0] ADCout;
   logic          ADCvalid;

   modport master (input CMPin, output FBout, output ADCout, output ADCvalid);
   modport slave  (output CMPin, input FBout, input ADCout, input ADCvalid);
endinterface

`default_nettype wire

// File: rtl/sigma_delta_adc_cic2_decimator.sv
// cic2_decimator: sinc2 decimator (two integrators, decimation counter, two combs, saturation).
`default_nettype none

module cic2_decimator
   import sigma_delta_pkg::*;
#(
   parameter int DEC_LOG2 = 7,
   parameter int OUT_W    = 14
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             b_i,
   output logic             tick_o,
   output logic [OUT_W-1:0] sample_o
);

   localparam int W  = cic_width(DEC_LOG2);
   localparam int PW = 2 * DEC_LOG2;
   localparam int SH = PW - OUT_W;
   localparam logic [W-1:0] SAT_MAX = W'(cic_sat_max(DEC_LOG2));

   logic [W-1:0]        i1_q, i2_q, i2_prev_q, c1_prev_q;
   logic [DEC_LOG2-1:0] d_q;
   logic [W-1:0]        c1_d, c2_d;
   logic [PW-1:0]       c2_sat;

   assign tick_o = &d_q;

   // Modulo arithmetic is deliberate: the combs recover the true count despite integrator wrap.
   always_comb begin
      c1_d   = i2_q - i2_prev_q;
      c2_d   = c1_d - c1_prev_q;
      c2_sat = (c2_d > SAT_MAX) ? SAT_MAX[PW-1:0] : c2_d[PW-1:0];
   end

   assign sample_o = OUT_W'(c2_sat >> SH);

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         i1_q      <= '0;
         i2_q      <= '0;
         i2_prev_q <= '0;
         c1_prev_q <= '0;
         d_q       <= '0;
      end else begin
         i1_q <= i1_q + W'(b_i);
         i2_q <= i2_q + i1_q;
         d_q  <= d_q + DEC_LOG2'(1);
         if (tick_o) begin
            i2_prev_q <= i2_q;
            c1_prev_q <= c1_d;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sigma_delta_adc.sv
// sigma_delta_adc: first-order loop front end (synchronizer, feedback flop) around a sinc2 decimator.
`default_nettype none

module sigma_delta_adc
   import sigma_delta_pkg::*;
#(
   parameter int   MSBO     = 13,
   parameter int   DEC_LOG2 = 7,
   parameter logic INV      = 1'b1
) (
   input logic                CLK,
   input logic                RESET,
   sigma_delta_adc_if.master  adc
);

   if (2 * DEC_LOG2 < MSBO + 1) begin : g_bad_params
      $error("sigma_delta_adc: 2*DEC_LOG2 must be >= MSBO+1");
   end

   logic          sync1_q, sync2_q;
   logic          fb_q;
   logic [MSBO:0] adcout_q;
   logic          adcvalid_q;
   logic          tick;
   logic [MSBO:0] sample;
   logic          sample_en;
   settle_state_e settle_q, settle_d;

   cic2_decimator #(
      .DEC_LOG2 (DEC_LOG2),
      .OUT_W    (MSBO + 1)
   ) u_cic (
      .CLK      (CLK),
      .RESET    (RESET),
      .b_i      (sync2_q),
      .tick_o   (tick),
      .sample_o (sample)
   );

   // The combs hold garbage history for the first two ticks after reset; drop those samples.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) settle_q <= SETTLE_0;
      else       settle_q <= settle_d;
   end

   always_comb begin
      settle_d = settle_q;
      if (tick) begin
         case (settle_q)
            SETTLE_0: settle_d = SETTLE_1;
            SETTLE_1: settle_d = SETTLE_RUN;
            default:  settle_d = SETTLE_RUN;
         endcase
      end
   end

   always_comb begin
      sample_en = tick && (settle_q == SETTLE_RUN);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         fb_q       <= INV;
         adcout_q   <= '0;
         adcvalid_q <= 1'b0;
      end else begin
         sync1_q    <= adc.CMPin;
         sync2_q    <= sync1_q;
         fb_q       <= sync2_q ^ INV;
         adcvalid_q <= sample_en;
         if (sample_en) adcout_q <= sample;
      end
   end

   assign adc.FBout    = fb_q;
   assign adc.ADCout   = adcout_q;
   assign adc.ADCvalid = adcvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_sigma_delta_adc.sv
// tb_sigma_delta_adc: checks the ADC against a windowed-sum reference computed from the bit history.
`default_nettype none

module tb_sigma_delta_adc;

   localparam int MSBO     = 13;
   localparam int DEC_LOG2 = 7;
   localparam int R        = 1 << DEC_LOG2;
   localparam int SH       = 2 * DEC_LOG2 - (MSBO + 1);
   localparam int MAXE     = 80000;

   logic CLK   = 1'b0;
   logic RESET = 1'b1;

   sigma_delta_adc_if #(.MSBO(MSBO)) adc_if ();

   sigma_delta_adc #(.MSBO(MSBO), .DEC_LOG2(DEC_LOG2), .INV(1'b1)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .adc   (adc_if)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: edges counted from reset release; b at edge e is CMPin seen at edge e-2.
   // ones_pref[j] is the count of ones among b_1..b_j; a sample is the second difference
   // of window sums of that running count, with no finite-width wrap.
   int     m_edge = 0;
   bit     cmp_hist [0:MAXE];
   int     ones_pref[0:MAXE];
   longint c1_prev = 0;
   int     exp_fb = 1, exp_valid = 0, exp_out = 0;

   always @(posedge CLK) begin
      if (RESET) begin
         m_edge       = 0;
         ones_pref[0] = 0;
         c1_prev      = 0;
         exp_fb       = 1;
         exp_valid    = 0;
         exp_out      = 0;
      end else if (m_edge < MAXE) begin
         int     b;
         longint c1, c2;
         m_edge++;
         cmp_hist[m_edge]  = adc_if.CMPin;
         b                 = (m_edge >= 3) ? int'(cmp_hist[m_edge-2]) : 0;
         ones_pref[m_edge] = ones_pref[m_edge-1] + b;
         exp_fb            = b ^ 1;
         exp_valid         = 0;
         if (m_edge % R == 0) begin
            int m;
            m  = m_edge / R;
            c1 = 0;
            for (int j = (m - 1) * R - 1; j <= m * R - 2; j++)
               if (j >= 0) c1 += ones_pref[j];
            c2      = c1 - c1_prev;
            c1_prev = c1;
            if (m >= 3) begin
               exp_valid = 1;
               exp_out   = int'(((c2 >= R * R) ? R * R - 1 : c2) >> SH);
            end
         end
      end
   end

   int first_valid = -1, last_valid = -1, last_gap = -1;

   always @(negedge CLK) begin
      check("fbout",    int'(adc_if.FBout),    exp_fb);
      check("adcvalid", int'(adc_if.ADCvalid), exp_valid);
      check("adcout",   int'(adc_if.ADCout),   exp_out);
      if (RESET) begin
         first_valid = -1;
         last_valid  = -1;
         last_gap    = -1;
      end else if (adc_if.ADCvalid) begin
         if (first_valid < 0) first_valid = m_edge;
         else last_gap = m_edge - last_valid;
         last_valid = m_edge;
      end
   end

   function automatic bit pattern(input int mode, input int k);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return k[0];
         3:       return (k % 4) == 0;
         default: return ($urandom_range(0, 2) == 0);
      endcase
   endfunction

   task automatic run(input int n, input int mode);
      for (int k = 0; k < n; k++) begin
         @(negedge CLK);
         #1 adc_if.CMPin = pattern(mode, k);
      end
   endtask

   task automatic do_reset(input bit first_cmp);
      @(negedge CLK);
      #1 RESET = 1'b1;
      adc_if.CMPin = first_cmp;
      repeat (2) @(negedge CLK);
      #1 RESET = 1'b0;
   endtask

   initial begin
      adc_if.CMPin = 1'b0;
      repeat (3) @(negedge CLK);
      #1;
      check("reset_fbout",    int'(adc_if.FBout),    1);
      check("reset_adcvalid", int'(adc_if.ADCvalid), 0);
      check("reset_adcout",   int'(adc_if.ADCout),   0);

      // Input held low: first sample after edge 3R, value 0.
      do_reset(1'b0);
      run(3 * R + 10, 0);
      check("zero_first_valid_edge", first_valid, 3 * R);
      check("zero_adcout",           int'(adc_if.ADCout), 0);
      check("zero_model",            exp_out, 0);

      // Input held high: feedback flips after the third edge; full scale saturates.
      do_reset(1'b1);
      @(negedge CLK); @(negedge CLK); #1;
      check("ones_fb_edge2", int'(adc_if.FBout), 1);
      @(negedge CLK); #1;
      check("ones_fb_edge3", int'(adc_if.FBout), 0);
      run(5 * R, 1);
      check("ones_adcout", int'(adc_if.ADCout), 16383);
      check("ones_model",  exp_out, 16383);

      // Half density.
      do_reset(1'b0);
      run(6 * R, 2);
      check("half_adcout",  int'(adc_if.ADCout), 8192);
      check("half_model",   exp_out, 8192);
      check("half_spacing", last_gap, R);

      // Quarter density, pattern 1000.
      do_reset(1'b0);
      run(6 * R, 3);
      check("quarter_adcout", int'(adc_if.ADCout), 4096);
      check("quarter_model",  exp_out, 4096);

      // Random bits, then a reset landing at D=60 mid-period.
      do_reset(1'b0);
      run(5 * R, 4);
      begin
         int guard = 0;
         while ((m_edge % R) != 60 && guard < 2 * R) begin
            run(1, 4);
            guard++;
         end
         check("midreset_reached_d60", m_edge % R, 60);
      end
      RESET = 1'b1;
      #1;
      check("midreset_fbout",    int'(adc_if.FBout),    1);
      check("midreset_adcvalid", int'(adc_if.ADCvalid), 0);
      check("midreset_adcout",   int'(adc_if.ADCout),   0);
      @(negedge CLK);
      #1 RESET = 1'b0;
      run(4 * R, 4);
      check("midreset_first_valid_edge", first_valid, 3 * R);
      check("random_spacing",            last_gap, R);

      // Long half-density run: integrators wrap many times.
      do_reset(1'b0);
      run(72000, 2);
      check("wrap_adcout",  int'(adc_if.ADCout), 8192);
      check("wrap_model",   exp_out, 8192);
      check("wrap_spacing", last_gap, R);

      @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
